// File: rtl/rvee_exec.sv
// rvee_exec: single-entry execute stage for an RV32 pipeline.
// Takes one decoded instruction at a time, computes the ALU or link result,
// resolves jumps and branches into a one-cycle fetch redirect, and holds the
// result in an output register for the memory stage. Shifts with a non-zero
// amount are done one bit per cycle in that output register.
module rvee_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  // decode side
  input  logic            d_valid,
  output logic            d_ready,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_rs1,
  input  logic [XLEN-1:0] d_rs2,
  input  logic [XLEN-1:0] d_imm,
  input  logic            d_op1_pc,
  input  logic            d_op2_imm,
  input  logic [3:0]      d_alu_op,
  input  logic            d_branch,
  input  logic [2:0]      d_cond,
  input  logic            d_jal,
  input  logic            d_jalr,
  input  logic            d_rd_we,
  input  logic [4:0]      d_rd,
  input  logic            d_mem_load,
  input  logic            d_mem_store,
  input  logic [1:0]      d_mem_size,
  input  logic            d_mem_sext,
  // memory-stage side
  output logic            e_valid,
  input  logic            e_ready,
  output logic [XLEN-1:0] e_pc,
  output logic [XLEN-1:0] e_result,
  output logic [XLEN-1:0] e_mem_data,
  output logic            e_rd_we,
  output logic [4:0]      e_rd,
  output logic            e_mem_load,
  output logic            e_mem_store,
  output logic [1:0]      e_mem_size,
  output logic            e_mem_sext,
  // fetch redirect
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic            accept;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] load_value;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] redir_target;
  logic [XLEN-1:0] shift_next;
  logic            is_jump;
  logic            is_shift;
  logic [4:0]      shamt;
  logic            needs_shift;
  logic            branch_taken;
  logic            take_redirect;
  logic [4:0]      shift_cnt;
  logic [3:0]      shift_op;

  assign op_a     = d_op1_pc  ? d_pc  : d_rs1;
  assign op_b     = d_op2_imm ? d_imm : d_rs2;
  assign shamt    = op_b[4:0];
  assign is_jump  = d_jal | d_jalr;
  assign is_shift = (d_alu_op == OP_SLL) | (d_alu_op == OP_SRL) | (d_alu_op == OP_SRA);
  // Jumps always produce the link address, so they never take the shift path.
  assign needs_shift = is_shift & ~is_jump & (shamt != 5'd0);

  // Single-cycle ALU; shift ops pass operand A through, which is the final
  // answer for a zero amount and the seed value for the iterative shifter.
  always_comb begin
    alu_result = '0;
    case (d_alu_op)
      OP_ADD:   alu_result = op_a + op_b;
      OP_SUB:   alu_result = op_a - op_b;
      OP_SLL:   alu_result = op_a;
      OP_SRL:   alu_result = op_a;
      OP_SRA:   alu_result = op_a;
      OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:   alu_result = op_a ^ op_b;
      OP_OR:    alu_result = op_a | op_b;
      OP_AND:   alu_result = op_a & op_b;
      OP_PASSB: alu_result = op_b;
      default:  alu_result = '0;
    endcase
  end

  assign load_value = is_jump ? (d_pc + XLEN'(4)) : alu_result;

  // Branch condition on the raw register operands, RISC-V funct3 encoding.
  always_comb begin
    branch_taken = 1'b0;
    case (d_cond)
      3'd0:    branch_taken = (d_rs1 == d_rs2);
      3'd1:    branch_taken = (d_rs1 != d_rs2);
      3'd4:    branch_taken = ($signed(d_rs1) <  $signed(d_rs2));
      3'd5:    branch_taken = ($signed(d_rs1) >= $signed(d_rs2));
      3'd6:    branch_taken = (d_rs1 <  d_rs2);
      3'd7:    branch_taken = (d_rs1 >= d_rs2);
      default: branch_taken = 1'b0;
    endcase
  end

  assign take_redirect = is_jump | (d_branch & branch_taken);
  assign pc_imm        = d_pc + d_imm;
  assign jalr_sum      = d_rs1 + d_imm;
  assign redir_target  = d_jalr ? (jalr_sum & ~XLEN'(1)) : pc_imm;

  // One-bit step of the iterative shifter, applied to the output register.
  always_comb begin
    shift_next = e_result;
    case (shift_op)
      OP_SLL:  shift_next = {e_result[XLEN-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, e_result[XLEN-1:1]};
      OP_SRA:  shift_next = {e_result[XLEN-1], e_result[XLEN-1:1]};
      default: shift_next = e_result;
    endcase
  end

  // Handshake towards decode: open when empty, or when the held result leaves.
  always_comb begin
    d_ready = 1'b0;
    case (state)
      IDLE:    d_ready = 1'b1;
      FULL:    d_ready = e_ready;
      default: d_ready = 1'b0;
    endcase
    if (rst) d_ready = 1'b0;
  end

  assign accept = d_valid & d_ready;

  // Next-state logic for the empty / shifting / holding machine.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = needs_shift ? SHIFT : FULL;
      end
      FULL: begin
        if (accept)       state_next = needs_shift ? SHIFT : FULL;
        else if (e_ready) state_next = IDLE;
      end
      SHIFT: begin
        if (shift_cnt == 5'd1) state_next = FULL;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign e_valid = (state == FULL);

  // Output register, shifter bookkeeping and redirect pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_pc        <= '0;
      e_result    <= '0;
      e_mem_data  <= '0;
      e_rd_we     <= 1'b0;
      e_rd        <= '0;
      e_mem_load  <= 1'b0;
      e_mem_store <= 1'b0;
      e_mem_size  <= '0;
      e_mem_sext  <= 1'b0;
      shift_cnt   <= '0;
      shift_op    <= OP_ADD;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else begin
      redir_valid <= accept & take_redirect;
      if (accept & take_redirect) redir_pc <= redir_target;
      if (accept) begin
        e_pc        <= d_pc;
        e_result    <= load_value;
        e_mem_data  <= d_rs2;
        e_rd_we     <= d_rd_we;
        e_rd        <= d_rd;
        e_mem_load  <= d_mem_load;
        e_mem_store <= d_mem_store;
        e_mem_size  <= d_mem_size;
        e_mem_sext  <= d_mem_sext;
        shift_cnt   <= shamt;
        shift_op    <= d_alu_op;
      end else if (state == SHIFT) begin
        e_result  <= shift_next;
        shift_cnt <= shift_cnt - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_rvee_exec.sv
// tb_rvee_exec: table-driven, scoreboarded bench for the execute stage,
// plus hand-written timing sequences for shifts, backpressure, redirects
// and reset.
module tb_rvee_exec;

  logic        clk;
  logic        rst;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc, d_rs1, d_rs2, d_imm;
  logic        d_op1_pc, d_op2_imm;
  logic [3:0]  d_alu_op;
  logic        d_branch;
  logic [2:0]  d_cond;
  logic        d_jal, d_jalr;
  logic        d_rd_we;
  logic [4:0]  d_rd;
  logic        d_mem_load, d_mem_store;
  logic [1:0]  d_mem_size;
  logic        d_mem_sext;
  logic        e_valid;
  logic        e_ready;
  logic [31:0] e_pc, e_result, e_mem_data;
  logic        e_rd_we;
  logic [4:0]  e_rd;
  logic        e_mem_load, e_mem_store;
  logic [1:0]  e_mem_size;
  logic        e_mem_sext;
  logic        redir_valid;
  logic [31:0] redir_pc;

  rvee_exec #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_pc(d_pc), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_imm(d_imm),
    .d_op1_pc(d_op1_pc), .d_op2_imm(d_op2_imm), .d_alu_op(d_alu_op),
    .d_branch(d_branch), .d_cond(d_cond), .d_jal(d_jal), .d_jalr(d_jalr),
    .d_rd_we(d_rd_we), .d_rd(d_rd), .d_mem_load(d_mem_load),
    .d_mem_store(d_mem_store), .d_mem_size(d_mem_size), .d_mem_sext(d_mem_sext),
    .e_valid(e_valid), .e_ready(e_ready),
    .e_pc(e_pc), .e_result(e_result), .e_mem_data(e_mem_data),
    .e_rd_we(e_rd_we), .e_rd(e_rd), .e_mem_load(e_mem_load),
    .e_mem_store(e_mem_store), .e_mem_size(e_mem_size), .e_mem_sext(e_mem_sext),
    .redir_valid(redir_valid), .redir_pc(redir_pc)
  );

  typedef struct {
    logic [3:0]  op;
    logic        op1_pc, op2_imm, jal, jalr, branch;
    logic [2:0]  cond;
    logic [31:0] pc, rs1, rs2, imm;
    logic [31:0] exp_result;
    logic        exp_redir;
    logic [31:0] exp_redir_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc, result, mem_data;
    logic [10:0] side;
  } out_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];
  out_t exp_q [$];
  logic [31:0] redir_q [$];
  int checks = 0;
  int errors = 0;
  int seq_id = 0;
  bit stream_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] op, input logic op1_pc, input logic op2_imm,
                              input logic jal, input logic jalr, input logic branch,
                              input logic [2:0] cond, input logic [31:0] pc, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [31:0] exp_result, input logic exp_redir,
                              input logic [31:0] exp_redir_pc);
    vec_t v;
    v.op = op; v.op1_pc = op1_pc; v.op2_imm = op2_imm; v.jal = jal; v.jalr = jalr;
    v.branch = branch; v.cond = cond; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.exp_result = exp_result; v.exp_redir = exp_redir; v.exp_redir_pc = exp_redir_pc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one instruction until accepted; optionally records its expected output.
  task automatic applyStimulus(input vec_t v, input bit track);
    out_t o;
    bit accepted;
    int waited;
    seq_id++;
    d_pc = v.pc; d_rs1 = v.rs1; d_rs2 = v.rs2; d_imm = v.imm;
    d_op1_pc = v.op1_pc; d_op2_imm = v.op2_imm; d_alu_op = v.op;
    d_branch = v.branch; d_cond = v.cond; d_jal = v.jal; d_jalr = v.jalr;
    d_rd = 5'(seq_id); d_rd_we = seq_id[0]; d_mem_load = seq_id[1];
    d_mem_store = seq_id[2]; d_mem_size = 2'(seq_id >> 3); d_mem_sext = ~seq_id[0];
    d_valid = 1'b1;
    if (track) begin
      o.pc = v.pc; o.result = v.exp_result; o.mem_data = v.rs2;
      o.side = {d_rd_we, d_rd, d_mem_load, d_mem_store, d_mem_size, d_mem_sext};
      exp_q.push_back(o);
      if (v.exp_redir) redir_q.push_back(v.exp_redir_pc);
    end
    accepted = 0;
    waited = 0;
    while (!accepted && waited < 400) begin
      @(negedge clk);
      if (d_ready) accepted = 1;
      else waited++;
      @(posedge clk);
    end
    #1;
    d_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept within 400 cycles");
    end
  endtask

  // Waits (bounded) until every expected output has been consumed.
  task automatic drain();
    for (int c = 0; c < 300 && (exp_q.size() != 0 || redir_q.size() != 0); c++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare each consumed output and each redirect pulse.
  always @(negedge clk) begin
    out_t exp;
    logic [31:0] rexp;
    if (!rst && e_valid && e_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got pc 0x%08h expected no output", e_pc);
      end else begin
        exp = exp_q.pop_front();
        checkOutput("result", e_result, exp.result);
        checkOutput("pc", e_pc, exp.pc);
        checkOutput("mem_data", e_mem_data, exp.mem_data);
        checkOutput("sideband", {21'd0, e_rd_we, e_rd, e_mem_load, e_mem_store, e_mem_size, e_mem_sext},
                    {21'd0, exp.side});
      end
    end
    if (!rst && redir_valid) begin
      if (redir_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_redirect: got 0x%08h expected no redirect", redir_pc);
      end else begin
        rexp = redir_q.pop_front();
        checkOutput("redir_pc", redir_pc, rexp);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int held;
    logic [31:0] first_result;
    //              op     pc imm jal jalr br cond pc            rs1           rs2           imm           result        redir pc
    vecs[0]  = mk(4'd0,  0, 1, 0, 0, 0, 3'd0, 32'h10,       32'd5,        32'd0,        32'd7,        32'd12,       0, 32'h0);
    vecs[1]  = mk(4'd1,  0, 0, 0, 0, 0, 3'd0, 32'h14,       32'd3,        32'd5,        32'd0,        32'hFFFFFFFE, 0, 32'h0);
    vecs[2]  = mk(4'd2,  0, 0, 0, 0, 0, 3'd0, 32'h18,       32'd1,        32'd31,       32'd0,        32'h80000000, 0, 32'h0);
    vecs[3]  = mk(4'd3,  0, 0, 0, 0, 0, 3'd0, 32'h1C,       32'hFFFFFFFF, 32'd1,        32'd0,        32'd1,        0, 32'h0);
    vecs[4]  = mk(4'd4,  0, 0, 0, 0, 0, 3'd0, 32'h20,       32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        0, 32'h0);
    vecs[5]  = mk(4'd5,  0, 0, 0, 0, 0, 3'd0, 32'h24,       32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'hFF00FF00, 0, 32'h0);
    vecs[6]  = mk(4'd6,  0, 0, 0, 0, 0, 3'd0, 32'h28,       32'h80000000, 32'h24,       32'd0,        32'h08000000, 0, 32'h0);
    vecs[7]  = mk(4'd7,  0, 1, 0, 0, 0, 3'd0, 32'h2C,       32'h80000000, 32'd0,        32'd4,        32'hF8000000, 0, 32'h0);
    vecs[8]  = mk(4'd8,  0, 0, 0, 0, 0, 3'd0, 32'h30,       32'h00FF0000, 32'h0000FF00, 32'd0,        32'h00FFFF00, 0, 32'h0);
    vecs[9]  = mk(4'd9,  0, 0, 0, 0, 0, 3'd0, 32'h34,       32'h12345678, 32'h0F0F0F0F, 32'd0,        32'h02040608, 0, 32'h0);
    vecs[10] = mk(4'd10, 0, 1, 0, 0, 0, 3'd0, 32'h38,       32'd9,        32'd0,        32'hABCDE000, 32'hABCDE000, 0, 32'h0);
    vecs[11] = mk(4'd11, 0, 0, 0, 0, 0, 3'd0, 32'h3C,       32'd5,        32'd6,        32'd0,        32'd0,        0, 32'h0);
    vecs[12] = mk(4'd2,  0, 0, 0, 0, 0, 3'd0, 32'h40,       32'h1234,     32'd0,        32'd0,        32'h1234,     0, 32'h0);
    vecs[13] = mk(4'd0,  1, 1, 0, 0, 0, 3'd0, 32'h200,      32'd77,       32'd0,        32'h10,       32'h210,      0, 32'h0);
    vecs[14] = mk(4'd0,  0, 1, 0, 0, 0, 3'd0, 32'h44,       32'hFFFFFFFF, 32'd0,        32'd1,        32'd0,        0, 32'h0);
    vecs[15] = mk(4'd2,  0, 1, 1, 0, 0, 3'd0, 32'h300,      32'd0,        32'd0,        32'h44,       32'h304,      1, 32'h344);
    vecs[16] = mk(4'd0,  0, 1, 0, 1, 0, 3'd0, 32'h40,       32'h203,      32'd0,        32'd2,        32'h44,       1, 32'h204);
    vecs[17] = mk(4'd1,  0, 0, 0, 0, 1, 3'd4, 32'h100,      32'hFFFFFFFF, 32'd1,        32'h20,       32'hFFFFFFFE, 1, 32'h120);
    vecs[18] = mk(4'd1,  0, 0, 0, 0, 1, 3'd5, 32'h100,      32'hFFFFFFFF, 32'd1,        32'h20,       32'hFFFFFFFE, 0, 32'h0);
    vecs[19] = mk(4'd0,  0, 0, 0, 0, 1, 3'd0, 32'h500,      32'd7,        32'd7,        32'hFFFFFFF0, 32'd14,       1, 32'h4F0);
    vecs[20] = mk(4'd1,  0, 0, 0, 0, 1, 3'd6, 32'h600,      32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFE, 0, 32'h0);
    vecs[21] = mk(4'd1,  0, 0, 0, 0, 1, 3'd2, 32'h700,      32'd9,        32'd9,        32'h40,       32'd0,        0, 32'h0);

    rst = 1'b1; d_valid = 1'b0; e_ready = 1'b0;
    d_pc = '0; d_rs1 = '0; d_rs2 = '0; d_imm = '0; d_op1_pc = 0; d_op2_imm = 0;
    d_alu_op = '0; d_branch = 0; d_cond = '0; d_jal = 0; d_jalr = 0;
    d_rd_we = 0; d_rd = '0; d_mem_load = 0; d_mem_store = 0; d_mem_size = '0; d_mem_sext = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("d_ready_in_reset", {31'd0, d_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_e_valid", {31'd0, e_valid}, 32'd0);
    checkOutput("reset_redir_valid", {31'd0, redir_valid}, 32'd0);
    checkOutput("reset_e_result", e_result, 32'd0);
    checkOutput("reset_d_ready", {31'd0, d_ready}, 32'd1);
    @(posedge clk); #1;
    e_ready = 1'b1;

    // ADD latency: output in the cycle after accept, no redirect
    applyStimulus(vecs[0], 1);
    @(negedge clk);
    checkOutput("add_e_valid_n1", {31'd0, e_valid}, 32'd1);
    checkOutput("add_result_n1", e_result, 32'd12);
    checkOutput("add_no_redirect", {31'd0, redir_valid}, 32'd0);
    drain();

    // SRA by 4: four stalled cycles, output in cycle N+5
    applyStimulus(vecs[7], 1);
    held = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d_ready || e_valid) held++;
    end
    checkOutput("sra_stall_cycles", held, 32'd0);
    @(negedge clk);
    checkOutput("sra_e_valid_n5", {31'd0, e_valid}, 32'd1);
    drain();

    // Table of ALU / jump / branch cases with free-flowing output
    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], 1);
    drain();

    // JAL under backpressure: redirect is a single pulse anyway
    e_ready = 1'b0;
    applyStimulus(mk(4'd1, 0, 0, 1, 0, 0, 3'd0, 32'h300, 32'd8, 32'd3, 32'h40, 32'h304, 1, 32'h340), 1);
    @(negedge clk);
    checkOutput("jal_redir_pulse", {31'd0, redir_valid}, 32'd1);
    checkOutput("jal_redir_pc", redir_pc, 32'h340);
    @(negedge clk);
    checkOutput("jal_redir_single", {31'd0, redir_valid}, 32'd0);
    checkOutput("jal_held_valid", {31'd0, e_valid}, 32'd1);
    @(posedge clk); #1;
    e_ready = 1'b1;
    drain();

    // Back-to-back ADDs with three stalled cycles
    e_ready = 1'b0;
    applyStimulus(vecs[0], 1);
    first_result = 32'd12;
    fork
      applyStimulus(mk(4'd0, 0, 0, 0, 0, 0, 3'd0, 32'h80, 32'd100, 32'd23, 32'd0, 32'd123, 0, 32'h0), 1);
      begin
        held = 0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (!e_valid || d_ready || e_result !== first_result || e_pc !== 32'h10) held++;
        end
        checkOutput("backpressure_hold", held, 32'd0);
        @(posedge clk); #1;
        e_ready = 1'b1;
      end
    join
    drain();

    // Random backpressure over the whole table: order and count preserved
    stream_done = 0;
    fork
      begin
        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], 1);
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          e_ready = 1'($urandom_range(0, 1));
        end
        e_ready = 1'b1;
      end
    join
    drain();

    // Reset two cycles into a shift of 10: the shift never produces output
    applyStimulus(mk(4'd2, 0, 0, 0, 0, 0, 3'd0, 32'h900, 32'd1, 32'd10, 32'd0, 32'd0, 0, 32'h0), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("d_ready_during_rst", {31'd0, d_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("d_ready_after_rst", {31'd0, d_ready}, 32'd1);
    checkOutput("e_result_after_rst", e_result, 32'd0);
    held = 0;
    for (int i = 0; i < 15; i++) begin
      if (e_valid) held++;
      @(negedge clk);
    end
    checkOutput("shift_discarded", held, 32'd0);

    // Reset while FULL discards the held instruction
    @(posedge clk); #1;
    e_ready = 1'b0;
    applyStimulus(vecs[9], 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    e_ready = 1'b1;
    @(negedge clk);
    checkOutput("full_discarded_valid", {31'd0, e_valid}, 32'd0);
    checkOutput("full_discarded_pc", e_pc, 32'd0);
    repeat (5) @(negedge clk);

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    checkOutput("redirects_empty", redir_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvee_exec.md
RVEE_EXEC -- requirements
Module: rvee_exec

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only XLEN=32 is supported (5-bit shift amount).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 d_valid  in  1  decode presents an instruction.
REQ-005 d_ready  out  1  stage accepts the instruction this cycle.
REQ-006 d_pc / d_rs1 / d_rs2 / d_imm  in  XLEN each  instruction PC, register operands, sign-extended immediate.
REQ-007 d_op1_pc / d_op2_imm  in  1 each  operand A = d_pc instead of d_rs1; operand B = d_imm instead of d_rs2.
REQ-008 d_alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB; others yield 0.
REQ-009 d_branch / d_cond  in  1 / 3  conditional branch; RISC-V funct3 (0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU; 2/3 never taken).
REQ-010 d_jal / d_jalr  in  1 each  unconditional jumps.
REQ-011 d_rd_we, d_rd, d_mem_load, d_mem_store, d_mem_size, d_mem_sext  in  1/5/1/1/2/1  sideband carried to the e_* outputs.
REQ-012 e_valid  out  1  output register holds an instruction for the memory stage.
REQ-013 e_ready  in  1  memory stage consumes the output this cycle.
REQ-014 e_pc, e_result, e_mem_data  out  XLEN each  PC; ALU or link result; store data (the d_rs2 value).
REQ-015 e_rd_we, e_rd, e_mem_load, e_mem_store, e_mem_size, e_mem_sext  out  1/5/1/1/2/1  registered sideband.
REQ-016 redir_valid / redir_pc  out  1 / XLEN  fetch redirect pulse and target.

Function
REQ-017 The state machine SHALL have three states: IDLE (empty), SHIFT (iterative shift), FULL (e_valid=1).
REQ-018 d_ready SHALL be 1 in IDLE, (e_ready) in FULL, 0 in SHIFT, and 0 while rst=1.
REQ-019 Accept is d_valid&&d_ready; from IDLE or FULL, an accepted non-shift op, or a shift with amount 0, SHALL load the output register and enter or stay in FULL, so e_valid rises in cycle N+1.
REQ-020 An accepted SLL/SRL/SRA with B[4:0]=k>0 SHALL enter SHIFT, shift one bit per cycle for k cycles, then enter FULL; e_valid rises in cycle N+1+k.
REQ-021 In FULL with e_ready=1 and no accept, the stage SHALL go to IDLE; with e_ready=0, all e_* outputs SHALL hold stable.
REQ-022 Arithmetic SHALL be modulo 2^XLEN; SLT is signed; SLTU is unsigned; SRA replicates bit XLEN-1; PASSB outputs B.
REQ-023 For d_jal or d_jalr, e_result SHALL be d_pc+4, independent of d_alu_op.
REQ-024 Redirect targets SHALL be: JAL = d_pc+d_imm; JALR = (d_rs1+d_imm) with bit 0 cleared; taken branch = d_pc+d_imm, with the condition comparing d_rs1 and d_rs2.
REQ-025 redir_valid SHALL pulse high for exactly cycle N+1 after accepting a jump or taken branch, regardless of e_ready; it SHALL stay 0 for a not-taken branch; redir_pc is valid only while redir_valid=1.
REQ-026 Branches SHALL still pass to the output with e_rd_we as supplied; flushing wrong-path instructions is done upstream.
REQ-027 Instruction order SHALL be preserved; no instruction SHALL be dropped or duplicated under any e_ready pattern.

Reset
REQ-028 In any cycle with rst=1, the stage SHALL enter IDLE, and in the following cycle e_valid, redir_valid and all e_* and redir_pc registers SHALL read 0.
REQ-029 Reset during SHIFT or FULL SHALL discard the in-flight instruction with no output.

Verification
REQ-030 ADD, d_rs1=5, d_imm=7, d_op2_imm=1, e_ready=1 -> e_valid in cycle N+1, e_result=12, redir_valid=0.
REQ-031 SRA, d_rs1=0x80000000, B=4 -> d_ready=0 for 4 cycles, e_valid in cycle N+5, e_result=0xF8000000.
REQ-032 BLT, d_pc=0x100, d_rs1=0xFFFFFFFF, d_rs2=1, d_imm=0x20 -> one-cycle redir_valid with redir_pc=0x120; the same operands with BGE -> no redirect.
REQ-033 JALR, d_pc=0x40, d_rs1=0x203, d_imm=2 -> redir_pc=0x204, e_result=0x44.
REQ-034 Back-to-back ADDs with e_ready=0 for 3 cycles -> the first output holds stable, d_ready=0, and both drain in order after e_ready=1.
REQ-035 rst=1 two cycles into a shift of 10 -> e_valid is never raised for that shift, and d_ready=1 in the first cycle after rst=0.
